// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key schedule: word and FSM state types,
// round-count derivation and GF(2^8) doubling.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  localparam logic [7:0] XTIME_POLY = 8'h1b;

  function automatic int nr_from_nk(input int nk);
    return nk + 32'sd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_expand.sv
// Streaming AES key expansion: produces one schedule word per cycle and hands
// out 128-bit round keys through a valid/ready staging register.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk,
  output logic [3:0]          rk_idx,
  output logic                done
);

  localparam int NK = KEY_BITS / 32'sd32;
  localparam int NR = nr_from_nk(NK);
  localparam logic [5:0] NK_W       = 6'(NK);
  localparam logic [5:0] LAST_WORD  = 6'(4 * NR + 3);
  localparam logic [2:0] LAST_PHASE = 3'(NK - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
  end

  state_t      state_r, state_n;
  word_t       win_r [NK];
  word_t       grp_r [3];
  logic [5:0]  word_idx_r;
  logic [2:0]  phase_r;
  logic [7:0]  rcon_r;
  logic [127:0] rk_r;
  logic [3:0]  rk_idx_r;
  logic        rk_valid_r;
  logic        busy_r;
  logic        done_r;

  logic        accept_s;
  logic        xfer_s;
  logic        last_xfer_s;
  logic        gen_active_s;
  logic        advance_s;
  logic        key_slot_s;
  logic        group_done_s;
  logic        rot_phase_s;
  logic        sub_phase_s;
  word_t       sub_in_s;
  word_t       sub_out_s;
  word_t       temp_s;
  word_t       key_word_s;
  word_t       new_word_s;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data(sub_in_s[8*b +: 8]),
      .sub (sub_out_s[8*b +: 8])
    );
  end

  // Handshake and word-slot control.
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && start;
    xfer_s       = rk_valid_r && rk_ready;
    last_xfer_s  = (state_r == ST_EXPAND) && xfer_s && (rk_idx_r == LAST_ROUND);
    gen_active_s = (state_r == ST_EXPAND) && (word_idx_r <= LAST_WORD);
    advance_s    = gen_active_s && (!rk_valid_r || rk_ready);
    key_slot_s   = word_idx_r < NK_W;
    group_done_s = advance_s && (word_idx_r[1:0] == 2'd3);
  end

  // Next schedule word; key words past round key 0 are replayed from the window.
  always_comb begin
    rot_phase_s = (phase_r == 3'd0);
    sub_phase_s = (NK == 8) && (phase_r == 3'd4);
    sub_in_s    = rot_phase_s ? {win_r[NK-1][23:0], win_r[NK-1][31:24]} : win_r[NK-1];
    if (rot_phase_s) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if (sub_phase_s) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = win_r[NK-1];
    end
    key_word_s = 32'h00000000;
    for (int k = 0; k < NK; k++) begin
      key_word_s = key_word_s | ((word_idx_r == 6'(k)) ? win_r[k] : 32'h00000000);
    end
    new_word_s = key_slot_s ? key_word_s : (win_r[0] ^ temp_s);
  end

  // FSM next state.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_n = ST_EXPAND;
        else       state_n = ST_IDLE;
      end
      ST_EXPAND: begin
        if (last_xfer_s) state_n = ST_IDLE;
        else             state_n = ST_EXPAND;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Window, counters, group accumulator and round-key staging register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) win_r[k] <= 32'h00000000;
      for (int k = 0; k < 3; k++) grp_r[k] <= 32'h00000000;
      word_idx_r <= 6'd0;
      phase_r    <= 3'd0;
      rcon_r     <= 8'h00;
      rk_r       <= 128'h0;
      rk_idx_r   <= 4'd0;
      rk_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= last_xfer_s;
      if (accept_s) begin
        for (int k = 0; k < NK; k++) win_r[k] <= key[KEY_BITS - 1 - 32*k -: 32];
        word_idx_r <= 6'd4;
        phase_r    <= 3'd0;
        rcon_r     <= 8'h01;
        rk_r       <= key[KEY_BITS-1 -: 128];
        rk_idx_r   <= 4'd0;
        rk_valid_r <= 1'b1;
        busy_r     <= 1'b1;
      end else begin
        if (advance_s) begin
          word_idx_r <= word_idx_r + 6'd1;
          if (!key_slot_s) begin
            for (int k = 0; k < NK - 1; k++) win_r[k] <= win_r[k+1];
            win_r[NK-1] <= new_word_s;
            phase_r     <= (phase_r == LAST_PHASE) ? 3'd0 : phase_r + 3'd1;
            if (rot_phase_s) rcon_r <= xtime(rcon_r);
          end
          case (word_idx_r[1:0])
            2'd0:    grp_r[0] <= new_word_s;
            2'd1:    grp_r[1] <= new_word_s;
            2'd2:    grp_r[2] <= new_word_s;
            default: ;
          endcase
        end
        if (group_done_s) begin
          rk_r       <= {grp_r[0], grp_r[1], grp_r[2], new_word_s};
          rk_idx_r   <= word_idx_r[5:2];
          rk_valid_r <= 1'b1;
        end else if (xfer_s) begin
          rk_valid_r <= 1'b0;
        end
        if (last_xfer_s) busy_r <= 1'b0;
      end
    end
  end

  assign busy     = busy_r;
  assign rk_valid = rk_valid_r;
  assign rk       = rk_r;
  assign rk_idx   = rk_idx_r;
  assign done     = done_r;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand with 128/192/256-bit instances and
// FIPS-197 reference round keys.
module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, rk_ready;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [127:0] rk_o   [3];
  logic [3:0]   idx_o  [3];
  logic         vld_o  [3];
  logic         busy_o [3];
  logic         done_o [3];

  aes_key_expand #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .reset(reset), .start(start), .key(key128), .busy(busy_o[0]),
    .rk_valid(vld_o[0]), .rk_ready(rk_ready), .rk(rk_o[0]), .rk_idx(idx_o[0]), .done(done_o[0]));
  aes_key_expand #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .reset(reset), .start(start), .key(key192), .busy(busy_o[1]),
    .rk_valid(vld_o[1]), .rk_ready(rk_ready), .rk(rk_o[1]), .rk_idx(idx_o[1]), .done(done_o[1]));
  aes_key_expand #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .reset(reset), .start(start), .key(key256), .busy(busy_o[2]),
    .rk_valid(vld_o[2]), .rk_ready(rk_ready), .rk(rk_o[2]), .rk_idx(idx_o[2]), .done(done_o[2]));

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ALT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] EXP128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int           checks = 0;
  int           errors = 0;
  logic [127:0] got      [3][16];
  int           xfer_cyc [3][16];
  int           n_got    [3];
  int           done_cnt [3];
  int           done_cyc [3];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Runs `budget` cycles starting at the negedge of cycle t0+1, logging transfers.
  task automatic collect(input int budget, input bit rnd, input int poke,
                         input logic [127:0] poke_key, input int ndut);
    logic         hold     [3];
    logic [127:0] prev_rk  [3];
    logic [3:0]   prev_idx [3];
    for (int d = 0; d < 3; d++) begin
      n_got[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1;
      hold[d] = 1'b0; prev_rk[d] = 128'h0; prev_idx[d] = 4'd0;
      for (int k = 0; k < 16; k++) begin
        got[d][k] = 128'h0; xfer_cyc[d][k] = -1;
      end
    end
    for (int c = 1; c <= budget; c++) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (c == poke);
      if (c == poke) key128 = poke_key;
      for (int d = 0; d < ndut; d++) begin
        if (hold[d]) begin
          check_eq("stall_rk", rk_o[d], prev_rk[d]);
          check_eq("stall_idx", 128'(idx_o[d]), 128'(prev_idx[d]));
          check_eq("stall_vld", 128'(vld_o[d]), 128'd1);
        end
        if (vld_o[d] && rk_ready) begin
          check_eq("idx_order", 128'(idx_o[d]), 128'(n_got[d]));
          if (n_got[d] < 16) begin
            got[d][n_got[d]] = rk_o[d];
            xfer_cyc[d][n_got[d]] = c;
          end
          n_got[d]++;
        end
        hold[d]     = vld_o[d] && !rk_ready;
        prev_rk[d]  = rk_o[d];
        prev_idx[d] = idx_o[d];
        if (done_o[d]) begin
          done_cnt[d]++;
          done_cyc[d] = c;
          check_eq("busy_at_done", 128'(busy_o[d]), 128'd0);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic verify128(input bit timed);
    check_eq("n_keys128", 128'(n_got[0]), 128'd11);
    for (int r = 0; r < 11; r++) check_eq("rk128", got[0][r], EXP128[r]);
    check_eq("done_once128", 128'(done_cnt[0]), 128'd1);
    if (timed) begin
      check_eq("rk0_time", 128'(xfer_cyc[0][0]), 128'd1);
      check_eq("rk1_time", 128'(xfer_cyc[0][1]), 128'd5);
      check_eq("done_time128", 128'(done_cyc[0]), 128'd42);
    end
  endtask

  task automatic kick(input logic [127:0] k128);
    @(negedge clk);
    key128 = k128; key192 = K192; key256 = K256; start = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_zero(input int ndut);
    for (int d = 0; d < ndut; d++) begin
      check_eq("zero_rk", rk_o[d], 128'h0);
      check_eq("zero_ctl", 128'({idx_o[d], vld_o[d], busy_o[d], done_o[d]}), 128'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; rk_ready = 1'b1;
    key128 = 128'h0; key192 = 192'h0; key256 = 256'h0;
    repeat (3) @(negedge clk);
    check_zero(3);
    reset = 1'b0;

    // All three key sizes, rk_ready held high.
    kick(KEY_A);
    for (int d = 0; d < 3; d++) check_eq("busy_after_accept", 128'(busy_o[d]), 128'd1);
    collect(62, 1'b0, -1, 128'h0, 3);
    verify128(1'b1);
    check_eq("n_keys192", 128'(n_got[1]), 128'd13);
    check_eq("rk0_192", got[1][0], K192[191:64]);
    check_eq("rk1_192", got[1][1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check_eq("rk12_192", got[1][12], 128'he98ba06f448c773c8ecc720401002202);
    check_eq("done_once192", 128'(done_cnt[1]), 128'd1);
    check_eq("done_time192", 128'(done_cyc[1]), 128'd50);
    check_eq("n_keys256", 128'(n_got[2]), 128'd15);
    check_eq("rk0_256", got[2][0], K256[255:128]);
    check_eq("rk1_256", got[2][1], K256[127:0]);
    check_eq("rk2_256", got[2][2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check_eq("rk14_256", got[2][14], 128'hfe4890d1e6188d0b046df344706c631e);
    check_eq("done_once256", 128'(done_cnt[2]), 128'd1);
    check_eq("done_time256", 128'(done_cyc[2]), 128'd58);

    // Random back-pressure.
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    kick(KEY_A);
    collect(400, 1'b1, -1, 128'h0, 1);
    verify128(1'b0);
    rk_ready = 1'b1;

    // Reset during expansion, then a clean restart.
    kick(KEY_A);
    collect(8, 1'b0, -1, 128'h0, 1);
    check_eq("busy_before_reset", 128'(busy_o[0]), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check_zero(3);
    reset = 1'b0;
    kick(KEY_A);
    collect(44, 1'b0, -1, 128'h0, 1);
    verify128(1'b1);

    // start with a different key while busy is ignored.
    kick(KEY_A);
    collect(44, 1'b0, 3, KEY_ALT, 1);
    verify128(1'b1);

    // start in the done cycle begins the next expansion immediately.
    kick(KEY_A);
    collect(42, 1'b0, 42, KEY_A, 1);
    verify128(1'b1);
    check_eq("restart_vld", 128'(vld_o[0]), 128'd1);
    check_eq("restart_idx", 128'(idx_o[0]), 128'd0);
    check_eq("restart_rk", rk_o[0], KEY_A);
    check_eq("restart_busy", 128'(busy_o[0]), 128'd1);
    collect(44, 1'b0, -1, 128'h0, 1);
    verify128(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
